// File: rtl/vga_timing_gen_if.sv
// Pixel-source / DAC-side bundle of the VGA timing generator.
// The generator (master) presents request coordinates and timing pulses,
// takes back the colour for those coordinates, and drives the packed DAC bus.
interface vga_timing_gen_if #(
    parameter int CW = 8
);
    logic [CW-1:0]   r;
    logic [CW-1:0]   g;
    logic [CW-1:0]   b;
    logic [9:0]      x;
    logic [9:0]      y;
    logic            pix_ce;
    logic            line_start;
    logic            frame_start;
    logic [3*CW+4:0] vga_out;

    modport master (
        input  r, g, b,
        output x, y, pix_ce, line_start, frame_start, vga_out
    );

    modport slave (
        output r, g, b,
        input  x, y, pix_ce, line_start, frame_start, vga_out
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing generator and DAC output stage.
// A clock divider yields one pixel step every CLK_DIV clocks; the h/v counters
// advance on that step and are presented as request coordinates. Blank/sync
// flags are delayed PIX_LATENCY steps so they meet the colour coming back from
// the pixel source, then colour, syncs, blank and vid_clk leave on one register.
module vga_timing_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int CLK_DIV     = 2,
    parameter int PIX_LATENCY = 1,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0,
    parameter int CW          = 8
) (
    input  logic             clk,
    input  logic             rst,
    vga_timing_gen_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    // Region bounds are 11 bits wide so a sync ending exactly at 1024 still compares.
    localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [3:0]  DIV_LAST   = 4'(CLK_DIV - 1);
    localparam logic [3:0]  VID_HIGH   = 4'(CLK_DIV / 2);

    logic [3:0]      div_q,     div_d;
    logic [9:0]      hcnt_q,    hcnt_d;
    logic [9:0]      vcnt_q,    vcnt_d;
    logic [3*CW-1:0] colour_q,  colour_d;
    logic            hsync_q,   hsync_d;
    logic            vsync_q,   vsync_d;
    logic            blank_n_q, blank_n_d;
    logic            sync_n_q,  sync_n_d;
    logic            vid_clk_q, vid_clk_d;

    logic            pix_ce_s;
    logic            line_start_s;
    logic            frame_start_s;
    logic [10:0]     hcnt_ext_s;
    logic [10:0]     vcnt_ext_s;
    // Flag bundle layout: [2] vsync active, [1] hsync active, [0] visible.
    logic [2:0]      flags_raw_s;
    logic [2:0]      flags_dly_s;

    // Clock divider, pixel-step pulse and h/v counter advance.
    always_comb begin
        pix_ce_s = (div_q == DIV_LAST);
        div_d    = pix_ce_s ? 4'd0 : (div_q + 4'd1);
        hcnt_d   = hcnt_q;
        vcnt_d   = vcnt_q;
        if (pix_ce_s) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = 10'd0;
                if (vcnt_q == V_LAST) begin
                    vcnt_d = 10'd0;
                end else begin
                    vcnt_d = vcnt_q + 10'd1;
                end
            end else begin
                hcnt_d = hcnt_q + 10'd1;
            end
        end else begin
            hcnt_d = hcnt_q;
            vcnt_d = vcnt_q;
        end
        line_start_s  = pix_ce_s & (hcnt_q == H_LAST);
        frame_start_s = line_start_s & (vcnt_q == V_LAST);
    end

    // Raw visible/sync flags for the coordinates currently being requested.
    always_comb begin
        hcnt_ext_s     = {1'b0, hcnt_q};
        vcnt_ext_s     = {1'b0, vcnt_q};
        flags_raw_s[0] = (hcnt_ext_s < H_ACT_END) & (vcnt_ext_s < V_ACT_END);
        flags_raw_s[1] = (hcnt_ext_s >= H_SYNC_BEG) & (hcnt_ext_s < H_SYNC_END);
        flags_raw_s[2] = (vcnt_ext_s >= V_SYNC_BEG) & (vcnt_ext_s < V_SYNC_END);
    end

    generate
        if (PIX_LATENCY == 0) begin : g_no_dly
            assign flags_dly_s = flags_raw_s;
        end else begin : g_dly
            logic [3*PIX_LATENCY-1:0] dly_q, dly_d;
            logic [3*PIX_LATENCY+2:0] chain_s;

            // Shift the flag pipeline by one stage per pixel step; newest flags enter at the bottom.
            always_comb begin
                chain_s = {dly_q, flags_raw_s};
                if (pix_ce_s) begin
                    dly_d = chain_s[3*PIX_LATENCY-1:0];
                end else begin
                    dly_d = dly_q;
                end
            end

            // Flag pipeline register; reset empties it to "blank, no sync".
            always_ff @(posedge clk) begin
                if (!rst) begin
                    dly_q <= {(3*PIX_LATENCY){1'b0}};
                end else begin
                    dly_q <= dly_d;
                end
            end

            assign flags_dly_s = dly_q[3*PIX_LATENCY-1 -: 3];
        end
    endgenerate

    // Output stage: on each pixel step capture aligned colour (forced black outside the visible area) and pin levels.
    always_comb begin
        colour_d  = colour_q;
        hsync_d   = hsync_q;
        vsync_d   = vsync_q;
        blank_n_d = blank_n_q;
        sync_n_d  = sync_n_q;
        if (pix_ce_s) begin
            if (flags_dly_s[0]) begin
                colour_d = {bus.b, bus.g, bus.r};
            end else begin
                colour_d = {(3*CW){1'b0}};
            end
            hsync_d   = HS_POL ? flags_dly_s[1] : ~flags_dly_s[1];
            vsync_d   = VS_POL ? flags_dly_s[2] : ~flags_dly_s[2];
            blank_n_d = flags_dly_s[0];
            sync_n_d  = ~(flags_dly_s[1] | flags_dly_s[2]);
        end else begin
            colour_d  = colour_q;
            hsync_d   = hsync_q;
            vsync_d   = vsync_q;
            blank_n_d = blank_n_q;
            sync_n_d  = sync_n_q;
        end
        // Rises mid-pixel, after the data register has changed.
        vid_clk_d = (div_d >= VID_HIGH);
    end

    // State and output registers with synchronous active-low reset; pins idle inactive.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q     <= 4'd0;
            hcnt_q    <= 10'd0;
            vcnt_q    <= 10'd0;
            colour_q  <= {(3*CW){1'b0}};
            hsync_q   <= ~HS_POL;
            vsync_q   <= ~VS_POL;
            blank_n_q <= 1'b0;
            sync_n_q  <= 1'b1;
            vid_clk_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            colour_q  <= colour_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            blank_n_q <= blank_n_d;
            sync_n_q  <= sync_n_d;
            vid_clk_q <= vid_clk_d;
        end
    end

    assign bus.x           = hcnt_q;
    assign bus.y           = vcnt_q;
    assign bus.pix_ce      = pix_ce_s;
    assign bus.line_start  = line_start_s;
    assign bus.frame_start = frame_start_s;
    assign bus.vga_out     = {vid_clk_q, sync_n_q, blank_n_q, vsync_q, hsync_q, colour_q};
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen.
// dut_a: 8x6 total geometry (H 4/1/2/1, V 3/1/1/1), CLK_DIV=3, no source latency,
//        combinational source r=x, g=y, b=5A; includes a mid-frame reset.
// dut_b: same geometry, CLK_DIV=2, source latency 2, positive sync polarity,
//        g/b all ones, r = x delayed two pixel steps.
// dut_c: default 640x480 timing, source latency 1 with r = x registered once;
//        first line only.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.CW(8)) bus_a ();
    vga_timing_gen_if #(.CW(8)) bus_b ();
    vga_timing_gen_if #(.CW(8)) bus_c ();

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(3), .PIX_LATENCY(0), .HS_POL(1'b0), .VS_POL(1'b0), .CW(8)
    ) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(2), .PIX_LATENCY(2), .HS_POL(1'b1), .VS_POL(1'b1), .CW(8)
    ) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

    vga_timing_gen #(.CW(8)) dut_c (.clk(clk), .rst(rst_b), .bus(bus_c));

    // Pixel sources.
    logic [7:0] b_p1 = 8'h00;
    logic [7:0] b_p2 = 8'h00;
    logic [7:0] c_rp = 8'h00;

    assign bus_a.r = bus_a.x[7:0];
    assign bus_a.g = bus_a.y[7:0];
    assign bus_a.b = 8'h5A;

    assign bus_b.r = b_p2;
    assign bus_b.g = 8'hFF;
    assign bus_b.b = 8'hFF;

    assign bus_c.r = c_rp;
    assign bus_c.g = 8'h00;
    assign bus_c.b = 8'h00;

    always @(posedge clk) begin
        if (bus_b.pix_ce) begin
            b_p1 <= bus_b.x[7:0];
            b_p2 <= b_p1;
        end
        if (bus_c.pix_ce) begin
            c_rp <= bus_c.x[7:0];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected state of an 8x6-geometry DUT at sample j (j = clocks since the last reset edge).
    task automatic sample_dut(input string p, input int j, input int dv, input int lat,
                              input bit pol, input bit src_a,
                              input logic [9:0] x, input logic [9:0] y,
                              input logic pce, input logic ls, input logic fs,
                              input logic [28:0] vo);
        int n, s, src, sh, sv;
        bit pce_e, ls_e, fs_e, act, hs, vs;
        logic [23:0] col;
        logic [28:0] vo_e;
        n     = j / dv;
        s     = n % 48;
        pce_e = ((j % dv) == (dv - 1));
        ls_e  = pce_e && ((s % 8) == 7);
        fs_e  = ls_e && ((s / 8) == 5);
        act   = 1'b0;
        hs    = 1'b0;
        vs    = 1'b0;
        col   = 24'h000000;
        if (n > lat) begin
            src = (n - 1 - lat) % 48;
            sh  = src % 8;
            sv  = src / 8;
            act = (sh < 4) && (sv < 3);
            hs  = (sh >= 5) && (sh < 7);
            vs  = (sv == 4);
            if (act) col = src_a ? {8'h5A, 8'(sv), 8'(sh)} : {16'hFFFF, 8'(sh)};
        end
        vo_e = {((j % dv) >= (dv / 2)), ~(hs | vs), act, (pol ? vs : ~vs), (pol ? hs : ~hs), col};
        check_eq({p, "_x"},           32'(x),   32'(s % 8));
        check_eq({p, "_y"},           32'(y),   32'(s / 8));
        check_eq({p, "_pix_ce"},      32'(pce), 32'(pce_e));
        check_eq({p, "_line_start"},  32'(ls),  32'(ls_e));
        check_eq({p, "_frame_start"}, 32'(fs),  32'(fs_e));
        check_eq({p, "_vga_out"},     32'(vo),  32'(vo_e));
    endtask

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        fork
            begin : run_a
                int fs_cnt, ls_cnt, bl_cnt, vid_cnt, first_fs;
                repeat (3) @(posedge clk);
                @(negedge clk);
                check_eq("a_rst_vga", 32'(bus_a.vga_out), 32'h0B00_0000);
                check_eq("a_rst_xy", {12'h000, bus_a.y, bus_a.x}, 32'h0000_0000);
                for (int j = 0; j < 232; j++) begin
                    sample_dut("a", j, 3, 0, 1'b0, 1'b1, bus_a.x, bus_a.y, bus_a.pix_ce,
                               bus_a.line_start, bus_a.frame_start, bus_a.vga_out);
                    if (j == 0) rst_a = 1'b1;
                    if (j == 231) begin
                        check_eq("a_pre_rst_x", 32'(bus_a.x), 32'd5);
                        check_eq("a_pre_rst_y", 32'(bus_a.y), 32'd3);
                        rst_a = 1'b0;
                    end
                    @(posedge clk);
                    @(negedge clk);
                end
                check_eq("a_mid_rst_vga", 32'(bus_a.vga_out), 32'h0B00_0000);
                check_eq("a_mid_rst_xy", {12'h000, bus_a.y, bus_a.x}, 32'h0000_0000);
                check_eq("a_mid_rst_pulses",
                         {29'd0, bus_a.pix_ce, bus_a.line_start, bus_a.frame_start}, 32'd0);
                fs_cnt = 0; ls_cnt = 0; bl_cnt = 0; vid_cnt = 0; first_fs = -1;
                for (int j = 0; j < 150; j++) begin
                    sample_dut("a2", j, 3, 0, 1'b0, 1'b1, bus_a.x, bus_a.y, bus_a.pix_ce,
                               bus_a.line_start, bus_a.frame_start, bus_a.vga_out);
                    if (j < 144) begin
                        if (bus_a.frame_start) fs_cnt++;
                        if (bus_a.line_start) ls_cnt++;
                        if (bus_a.vga_out[26]) bl_cnt++;
                        if (bus_a.vga_out[28]) vid_cnt++;
                    end
                    if (bus_a.frame_start && (first_fs < 0)) first_fs = j;
                    if (j == 0) rst_a = 1'b1;
                    @(posedge clk);
                    @(negedge clk);
                end
                check_eq("a_frame_starts", 32'(fs_cnt), 32'd1);
                check_eq("a_line_starts", 32'(ls_cnt), 32'd6);
                check_eq("a_blank_n_clks", 32'(bl_cnt), 32'd36);
                check_eq("a_vid_clk_high", 32'(vid_cnt), 32'd96);
                check_eq("a_first_frame_start", 32'(first_fs), 32'd143);
            end
            begin : run_b
                repeat (3) @(posedge clk);
                @(negedge clk);
                check_eq("b_rst_vga", 32'(bus_b.vga_out), 32'h0800_0000);
                for (int j = 0; j < 288; j++) begin
                    sample_dut("b", j, 2, 2, 1'b1, 1'b0, bus_b.x, bus_b.y, bus_b.pix_ce,
                               bus_b.line_start, bus_b.frame_start, bus_b.vga_out);
                    if (j == 0) rst_b = 1'b1;
                    @(posedge clk);
                    @(negedge clk);
                end
            end
            begin : run_c
                int first_hs, hs_cnt, first_bl, bl_cnt, first_ls, n;
                repeat (3) @(posedge clk);
                @(negedge clk);
                check_eq("c_rst_vga", 32'(bus_c.vga_out), 32'h0B00_0000);
                first_hs = -1; hs_cnt = 0; first_bl = -1; bl_cnt = 0; first_ls = -1;
                for (int j = 0; j < 1604; j++) begin
                    if ((j % 2) == 0) begin
                        n = j / 2;
                        if (!bus_c.vga_out[24]) begin
                            hs_cnt++;
                            if (first_hs < 0) first_hs = n;
                        end
                        if (bus_c.vga_out[26]) begin
                            bl_cnt++;
                            if (first_bl < 0) first_bl = n;
                        end
                        if (n == 2) check_eq("c_r_first_pixel", 32'(bus_c.vga_out[7:0]), 32'd0);
                        if (n == 3) check_eq("c_r_second_pixel", 32'(bus_c.vga_out[7:0]), 32'd1);
                    end
                    if (bus_c.line_start && (first_ls < 0)) first_ls = j;
                    @(posedge clk);
                    @(negedge clk);
                end
                check_eq("c_hsync_first_step", 32'(first_hs), 32'd658);
                check_eq("c_hsync_width", 32'(hs_cnt), 32'd96);
                check_eq("c_blank_n_first_step", 32'(first_bl), 32'd2);
                check_eq("c_blank_n_steps", 32'(bl_cnt), 32'd640);
                check_eq("c_first_line_start", 32'(first_ls), 32'd1599);
            end
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
